// File: rtl/vga_fb_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_fb_arbiter_pkg                                                       |
// | Video timing constants, framebuffer geometry and port-owner encoding.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package vga_fb_arbiter_pkg;

  // 640x480 @ 60 Hz timing, in pixel clocks / lines
  localparam int H_DISP_640  = 640;
  localparam int H_FRONT_640 = 16;
  localparam int H_SYNC_640  = 96;
  localparam int H_BACK_640  = 48;
  localparam int H_TOTAL_640 = H_DISP_640 + H_FRONT_640 + H_SYNC_640 + H_BACK_640;
  localparam int V_DISP_640  = 480;
  localparam int V_FRONT_640 = 10;
  localparam int V_SYNC_640  = 2;
  localparam int V_BACK_640  = 33;
  localparam int V_TOTAL_640 = V_DISP_640 + V_FRONT_640 + V_SYNC_640 + V_BACK_640;

  localparam int FB_DEPTH  = H_DISP_640 * V_DISP_640;
  localparam int FB_ADDR_W = 19;
  localparam int PIX_W     = 12;
  localparam int FB_RD_LAT = 3;

  typedef enum logic [0:0] {
    PORT_DRAIN = 1'b0,
    PORT_SCAN  = 1'b1
  } port_state_e;

  function automatic int fb_depth(input int h_disp, input int v_disp);
    return h_disp * v_disp;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fb_wr_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fb_wr_fifo                                                               |
// | Two-entry synchronous FIFO posting writer {addr,data} pairs.             |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module fb_wr_fifo #(
  parameter int WIDTH = 31
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [1:0]       level,
  output logic             empty
);

  logic [WIDTH-1:0] slot_q [2];
  logic [WIDTH-1:0] slot_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       level_q, level_d;
  logic             full;
  logic             do_push, do_pop;

  assign full     = (level_q == 2'd2);
  assign empty    = (level_q == 2'd0);
  assign level    = level_q;
  assign pop_data = slot_q[rd_ptr_q];

  // Push at level 2 is refused even with a concurrent pop; space frees next cycle.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    slot_d   = slot_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      slot_d[wr_ptr_q] = push_data;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    if (do_push && !do_pop) begin
      level_d = level_q + 2'd1;
    end else if (!do_push && do_pop) begin
      level_d = level_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q   <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      level_q  <= 2'd0;
    end else begin
      slot_q   <= slot_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_fb_arbiter                                                           |
// | Shares a single-port pixel RAM between scan-out and a posted writer.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
import vga_fb_arbiter_pkg::*;

module vga_fb_arbiter #(
  parameter int H_DISP = H_DISP_640,
  parameter int V_DISP = V_DISP_640,
  parameter int ADDR_W = FB_ADDR_W,
  parameter int DATA_W = PIX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disp_en,
  input  logic [9:0]        vga_xpos,
  input  logic [9:0]        vga_ypos,
  output logic [DATA_W-1:0] vga_data,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              wr_drop,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int                DEPTH     = fb_depth(H_DISP, V_DISP);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  port_state_e       port_q, port_d;
  logic              scan_rd_q, scan_rd_d;
  logic [ADDR_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] vga_data_q, vga_data_d;
  logic              wr_drop_q, wr_drop_d;

  logic [ADDR_W-1:0]        scan_addr;
  logic                     fifo_push, fifo_pop, fifo_empty;
  logic [1:0]               fifo_level;
  logic [ADDR_W+DATA_W-1:0] fifo_head;
  logic [ADDR_W-1:0]        head_addr;
  logic [DATA_W-1:0]        head_data;

  assign wr_ready  = (fifo_level < 2'd2);
  assign fifo_push = wr_valid && wr_ready;
  assign {head_addr, head_data} = fifo_head;

  fb_wr_fifo #(
    .WIDTH (ADDR_W + DATA_W)
  ) u_wr_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data ({wr_addr, wr_data}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .level     (fifo_level),
    .empty     (fifo_empty)
  );

  // Pixel (0,0) resynchronises the linear counter once per frame.
  assign scan_addr = (vga_xpos == 10'd0 && vga_ypos == 10'd0) ? '0 : scan_cnt_q;

  always_comb begin
    port_d      = PORT_DRAIN;
    scan_cnt_d  = scan_cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    wr_drop_d   = 1'b0;
    fifo_pop    = 1'b0;

    if (disp_en) begin
      port_d     = PORT_SCAN;
      mem_addr_d = scan_addr;
      scan_cnt_d = (scan_addr == LAST_ADDR) ? '0 : scan_addr + ADDR_W'(1);
    end else if (!fifo_empty) begin
      fifo_pop = 1'b1;
      if ({1'b0, head_addr} < DEPTH_EXT) begin
        mem_we_d    = 1'b1;
        mem_addr_d  = head_addr;
        mem_wdata_d = head_data;
      end else begin
        wr_drop_d = 1'b1;
      end
    end

    // RAM data lands one cycle after the port cycle; blank unless that was a scan.
    scan_rd_d  = (port_q == PORT_SCAN);
    vga_data_d = scan_rd_q ? mem_rdata : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      port_q      <= PORT_DRAIN;
      scan_rd_q   <= 1'b0;
      scan_cnt_q  <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      vga_data_q  <= '0;
      wr_drop_q   <= 1'b0;
    end else begin
      port_q      <= port_d;
      scan_rd_q   <= scan_rd_d;
      scan_cnt_q  <= scan_cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      vga_data_q  <= vga_data_d;
      wr_drop_q   <= wr_drop_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign vga_data  = vga_data_q;
  assign wr_drop   = wr_drop_q;

endmodule
`default_nettype wire
